pulp_iso_clamp_ctrl: RTL and testbench
======================================

Name: pulp_iso_clamp_ctrl

Overview:
Sequencer that drives the clamp enable of the output clamp level shifters, which force the outputs of a switchable power domain to 0, and the domain's power-switch enable. It takes a level-based power request and orders the events safely:
- Power-down: clamp first, then switch off.
- Power-up: switch on, wait for power-good, settle, then release the clamp.
Sits in the always-on domain directly upstream of the clamp cells; clamp_o fans out to every clamp_i in the domain.

Parameters:
CLAMP_SETUP, 4, cycles clamp_o is held before the power switch opens (min 1)
PWR_SETTLE, 8, cycles after pwr_good_i rises before the clamp is released (min 1)
RELEASE_HOLD, 2, cycles between clamp release and domain_on_o assertion (min 1)
TIMEOUT, 1024, max cycles waiting on pwr_good_i; used only with the optional feature
BOOT_ON, 1'b0, reset target: 0 = domain off and clamped; 1 = domain on and unclamped

Ports:
clk_i  in  1  clock, always-on domain
rst_i  in  1  synchronous, active-high reset
pwr_req_i  in  1  level request: 1 = domain on, 0 = domain off
pwr_good_i  in  1  power-good from the switch, already synchronised
pwr_sw_en_o  out  1  power-switch enable
clamp_o  out  1  clamp enable to the clamp level shifters (1 = outputs forced to 0)
domain_on_o  out  1  domain powered and unclamped; stable
domain_off_o  out  1  domain clamped and switched off; stable
busy_o  out  1  a sequence is in progress
err_o  out  1  timeout error flag; tied 0 unless the optional feature is compiled in

Behaviour:
- Single FSM with one down-counter (width CNT_W). All outputs are registered and decoded from state, so there are no combinational paths from inputs to outputs.
- States and their output values:
  - OFF: clamp=1, sw=0, domain_off=1
  - SW_ON: clamp=1, sw=1
  - SETTLE: clamp=1, sw=1
  - UNCLAMP: clamp=0, sw=1
  - ON: clamp=0, sw=1, domain_on=1
  - CLAMP: clamp=1, sw=1
  - SW_OFF: clamp=1, sw=0
- busy_o=1 in every state except OFF and ON.
- Reset:
  - BOOT_ON=0: state OFF, so clamp_o=1, pwr_sw_en_o=0, domain_off_o=1, all other outputs 0.
  - BOOT_ON=1: state ON.
  - Counter resets to 0, err_o resets to 0.
  - Reset asserted mid-sequence returns to the reset state in the next cycle regardless of the current state.
- Power-up sequence:
  - OFF with pwr_req_i=1 → SW_ON; pwr_sw_en_o rises 1 cycle after the request is sampled.
  - SW_ON: wait for pwr_good_i=1, then → SETTLE and load PWR_SETTLE-1.
  - SETTLE: count to 0 → UNCLAMP (clamp_o falls) and load RELEASE_HOLD-1.
  - UNCLAMP: count to 0 → ON.
  - Latency when pwr_good_i is already 1: clamp_o falls PWR_SETTLE+2 cycles after the request edge is sampled; domain_on_o rises RELEASE_HOLD cycles later.
- Power-down sequence:
  - ON with pwr_req_i=0 → CLAMP (clamp_o rises the next cycle) and load CLAMP_SETUP-1.
  - CLAMP: count to 0 → SW_OFF (pwr_sw_en_o falls).
  - SW_OFF: wait for pwr_good_i=0 → OFF.
- Invariants:
  - clamp_o=0 only while pwr_sw_en_o=1 and pwr_good_i has been seen high.
  - pwr_sw_en_o never falls while clamp_o=0.
  - clamp_o and pwr_sw_en_o never change in the same cycle.
- Request changes mid-sequence: a sequence always runs to its stable state (ON or OFF), then pwr_req_i is re-evaluated. A request pulse shorter than a sequence therefore produces a full up sequence followed by a full down sequence.
- pwr_good_i dropping while in ON or UNCLAMP: treated as a brown-out; go immediately to CLAMP, so clamp_o=1 the next cycle.
- pwr_req_i stable at the current state's target: no transitions.
- Counter arithmetic is unsigned and saturates at 0; no wrap-around.

Optional Feature:
Macro: PULP_ISO_CLAMP_CTRL_TIMEOUT_EN.
- Defined:
  - A wait counter runs in SW_ON and SW_OFF.
  - If it reaches TIMEOUT, set err_o (sticky until reset).
  - From SW_ON → CLAMP then SW_OFF, i.e. abort the power-up safely.
  - From SW_OFF → OFF.
- Undefined: no timeout logic; err_o tied 0; waits are unbounded.

Decomposition:
- Package pulp_iso_clamp_pkg holds:
  - state enum iso_state_e (OFF, SW_ON, SETTLE, UNCLAMP, ON, CLAMP, SW_OFF)
  - function cnt_width(max) returning $clog2(max+1)
  - default constants for the timing parameters
- Sub-module pulp_iso_delay_cnt: a loadable down-counter with a done flag, instantiated once for settle/hold timing and once for the timeout under the macro.

Test Plan:
- Reset with BOOT_ON=0, pwr_good_i=0 → clamp_o=1, pwr_sw_en_o=0, domain_off_o=1, busy_o=0.
- Power-up with defaults, pwr_req_i=1 at cycle 0 and pwr_good_i=1 at cycle 5:
  - pwr_sw_en_o=1 at cycle 1
  - clamp_o=0 at cycle 14
  - domain_on_o=1 at cycle 16
- Power-down from ON, pwr_req_i=0 at cycle 0:
  - clamp_o=1 at cycle 1
  - pwr_sw_en_o=0 at cycle 5
  - after pwr_good_i falls at cycle 7, domain_off_o=1 at cycle 8
- Brown-out: in ON, force pwr_good_i=0 → clamp_o=1 the next cycle; pwr_sw_en_o=0 4 cycles later.
- Request pulse: pwr_req_i high for 2 cycles from OFF → full up sequence, then full down sequence; assert the invariant "clamp_o=0 implies pwr_sw_en_o=1" on every cycle.
- With the macro, TIMEOUT=16 and pwr_good_i held 0 after the request → err_o=1 after 16 cycles in SW_ON, then pwr_sw_en_o=0 and the FSM reaches OFF. Separately, rst_i pulsed while in SETTLE → state OFF the next cycle.

Source files
------------

// File: rtl/pulp_iso_clamp_pkg.sv
// Shared types and timing defaults for the isolation-clamp power sequencer.
// Used by pulp_iso_clamp_ctrl and pulp_iso_delay_cnt.
package pulp_iso_clamp_pkg;

   typedef enum logic [2:0] {
      OFF     = 3'd0,
      SW_ON   = 3'd1,
      SETTLE  = 3'd2,
      UNCLAMP = 3'd3,
      ON      = 3'd4,
      CLAMP   = 3'd5,
      SW_OFF  = 3'd6
   } iso_state_e;

   localparam int unsigned DEF_CLAMP_SETUP  = 4;
   localparam int unsigned DEF_PWR_SETTLE   = 8;
   localparam int unsigned DEF_RELEASE_HOLD = 2;
   localparam int unsigned DEF_TIMEOUT      = 1024;

   // Bits needed to hold values 0..max; never less than one bit.
   function automatic int unsigned cnt_width(input int unsigned max);
      return (max < 1) ? 1 : $clog2(max + 1);
   endfunction

endpackage

// File: rtl/pulp_iso_delay_cnt.sv
// Loadable down-counter that saturates at zero; done_o is high while the count is zero.
module pulp_iso_delay_cnt #(
   parameter int unsigned W = 4
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         dec_i,
   output logic         done_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done_o = (cnt_q == '0);

endmodule

// File: rtl/pulp_iso_clamp_ctrl.sv
// Power-domain sequencer: orders clamp enable against power-switch enable.
// Optional pwr_good wait timeout is compiled in with PULP_ISO_CLAMP_CTRL_TIMEOUT_EN.
module pulp_iso_clamp_ctrl
   import pulp_iso_clamp_pkg::*;
#(
   parameter int unsigned CLAMP_SETUP  = DEF_CLAMP_SETUP,
   parameter int unsigned PWR_SETTLE   = DEF_PWR_SETTLE,
   parameter int unsigned RELEASE_HOLD = DEF_RELEASE_HOLD,
   parameter int unsigned TIMEOUT      = DEF_TIMEOUT,
   parameter logic        BOOT_ON      = 1'b0
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic pwr_req_i,
   input  logic pwr_good_i,
   output logic pwr_sw_en_o,
   output logic clamp_o,
   output logic domain_on_o,
   output logic domain_off_o,
   output logic busy_o,
   output logic err_o
);

   localparam int unsigned MAX_DLY_A = (CLAMP_SETUP > PWR_SETTLE) ? CLAMP_SETUP : PWR_SETTLE;
   localparam int unsigned MAX_DLY   = (MAX_DLY_A > RELEASE_HOLD) ? MAX_DLY_A : RELEASE_HOLD;
   localparam int unsigned CNT_W     = cnt_width(MAX_DLY);

   localparam logic [CNT_W-1:0] CLAMP_LD   = CNT_W'(CLAMP_SETUP - 1);
   localparam logic [CNT_W-1:0] SETTLE_LD  = CNT_W'(PWR_SETTLE - 1);
   localparam logic [CNT_W-1:0] RELEASE_LD = CNT_W'(RELEASE_HOLD - 1);

   localparam iso_state_e RST_STATE = BOOT_ON ? ON : OFF;

   iso_state_e       state_q, state_d;
   logic             dly_load, dly_dec, dly_done;
   logic [CNT_W-1:0] dly_val;
   logic             tmo;

   pulp_iso_delay_cnt #(.W(CNT_W)) u_dly_cnt (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .load_i     (dly_load),
      .load_val_i (dly_val),
      .dec_i      (dly_dec),
      .done_o     (dly_done)
   );

`ifdef PULP_ISO_CLAMP_CTRL_TIMEOUT_EN
   localparam int unsigned      TMO_W  = cnt_width(TIMEOUT);
   localparam logic [TMO_W-1:0] TMO_LD = TMO_W'(TIMEOUT - 1);

   logic in_wait, enter_wait, tmo_done, err_q;

   // The wait counter is re-armed on every entry into a pwr_good wait state.
   assign in_wait    = (state_q == SW_ON) || (state_q == SW_OFF);
   assign enter_wait = ((state_d == SW_ON) || (state_d == SW_OFF)) && (state_d != state_q);
   assign tmo        = in_wait && tmo_done;

   pulp_iso_delay_cnt #(.W(TMO_W)) u_tmo_cnt (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .load_i     (enter_wait),
      .load_val_i (TMO_LD),
      .dec_i      (in_wait),
      .done_o     (tmo_done)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         err_q <= 1'b0;
      end else if (tmo) begin
         err_q <= 1'b1;
      end
   end

   assign err_o = err_q;
`else
   assign tmo   = 1'b0;
   assign err_o = 1'b0;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= RST_STATE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      dly_load = 1'b0;
      dly_dec  = 1'b0;
      dly_val  = '0;
      case (state_q)
         OFF: begin
            if (pwr_req_i) state_d = SW_ON;
         end
         SW_ON: begin
            if (pwr_good_i) begin
               state_d  = SETTLE;
               dly_load = 1'b1;
               dly_val  = SETTLE_LD;
            end else if (tmo) begin
               // Power never came up: back out through the clamped path.
               state_d  = CLAMP;
               dly_load = 1'b1;
               dly_val  = CLAMP_LD;
            end
         end
         SETTLE: begin
            if (dly_done) begin
               state_d  = UNCLAMP;
               dly_load = 1'b1;
               dly_val  = RELEASE_LD;
            end else begin
               dly_dec = 1'b1;
            end
         end
         UNCLAMP: begin
            if (!pwr_good_i) begin
               state_d  = CLAMP;
               dly_load = 1'b1;
               dly_val  = CLAMP_LD;
            end else if (dly_done) begin
               state_d = ON;
            end else begin
               dly_dec = 1'b1;
            end
         end
         ON: begin
            if (!pwr_good_i || !pwr_req_i) begin
               state_d  = CLAMP;
               dly_load = 1'b1;
               dly_val  = CLAMP_LD;
            end
         end
         CLAMP: begin
            if (dly_done) begin
               state_d = SW_OFF;
            end else begin
               dly_dec = 1'b1;
            end
         end
         SW_OFF: begin
            if (!pwr_good_i || tmo) state_d = OFF;
         end
         default: begin
            state_d = RST_STATE;
         end
      endcase
   end

   // Outputs decode only the state register, so no input reaches an output combinationally.
   always_comb begin
      clamp_o      = 1'b1;
      pwr_sw_en_o  = 1'b0;
      domain_on_o  = 1'b0;
      domain_off_o = 1'b0;
      busy_o       = 1'b1;
      case (state_q)
         OFF: begin
            domain_off_o = 1'b1;
            busy_o       = 1'b0;
         end
         SW_ON, SETTLE, CLAMP: begin
            pwr_sw_en_o = 1'b1;
         end
         UNCLAMP: begin
            clamp_o     = 1'b0;
            pwr_sw_en_o = 1'b1;
         end
         ON: begin
            clamp_o     = 1'b0;
            pwr_sw_en_o = 1'b1;
            domain_on_o = 1'b1;
            busy_o      = 1'b0;
         end
         default: begin
            clamp_o = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_pulp_iso_clamp_ctrl.sv
// Directed bench for pulp_iso_clamp_ctrl; the timeout section runs only when
// PULP_ISO_CLAMP_CTRL_TIMEOUT_EN is defined.
module tb_pulp_iso_clamp_ctrl;

   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   logic pwr_req_i = 1'b0;
   logic pwr_good_i = 1'b0;
   logic pwr_sw_en_o, clamp_o, domain_on_o, domain_off_o, busy_o, err_o;

   int pass_cnt = 0;
   int chk_cnt  = 0;

   pulp_iso_clamp_ctrl #(
      .CLAMP_SETUP  (4),
      .PWR_SETTLE   (8),
      .RELEASE_HOLD (2),
      .TIMEOUT      (16),
      .BOOT_ON      (1'b0)
   ) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .pwr_req_i    (pwr_req_i),
      .pwr_good_i   (pwr_good_i),
      .pwr_sw_en_o  (pwr_sw_en_o),
      .clamp_o      (clamp_o),
      .domain_on_o  (domain_on_o),
      .domain_off_o (domain_off_o),
      .busy_o       (busy_o),
      .err_o        (err_o)
   );

   always #5 clk_i = ~clk_i;

   // Advance n clock edges; inputs change and outputs are sampled 1ns after the edge.
   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk_i);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic obs, input logic exp);
      chk_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
   endtask

   initial begin
      bit saw_on;
      bit saw_off;

      // Reset, BOOT_ON=0, pwr_good low
      step(3);
      rst_i = 1'b0;
      check("rst_clamp", clamp_o, 1'b1);
      check("rst_sw", pwr_sw_en_o, 1'b0);
      check("rst_off", domain_off_o, 1'b1);
      check("rst_on", domain_on_o, 1'b0);
      check("rst_busy", busy_o, 1'b0);
      check("rst_err", err_o, 1'b0);

      // Request held low: no movement
      step(3);
      check("idle_off", domain_off_o, 1'b1);
      check("idle_sw", pwr_sw_en_o, 1'b0);

      // Power-up: request at cycle 0, pwr_good at cycle 5
      pwr_req_i = 1'b1;
      step(1);
      check("up_sw_c1", pwr_sw_en_o, 1'b1);
      check("up_clamp_c1", clamp_o, 1'b1);
      check("up_busy_c1", busy_o, 1'b1);
      check("up_off_c1", domain_off_o, 1'b0);
      step(4);
      pwr_good_i = 1'b1;
      step(8);
      check("up_clamp_c13", clamp_o, 1'b1);
      step(1);
      check("up_clamp_c14", clamp_o, 1'b0);
      check("up_sw_c14", pwr_sw_en_o, 1'b1);
      check("up_on_c14", domain_on_o, 1'b0);
      step(1);
      check("up_on_c15", domain_on_o, 1'b0);
      step(1);
      check("up_on_c16", domain_on_o, 1'b1);
      check("up_busy_c16", busy_o, 1'b0);

      // Power-down from ON: request drops at cycle 0, pwr_good falls at cycle 7
      pwr_req_i = 1'b0;
      step(1);
      check("dn_clamp_c1", clamp_o, 1'b1);
      check("dn_on_c1", domain_on_o, 1'b0);
      check("dn_sw_c1", pwr_sw_en_o, 1'b1);
      step(3);
      check("dn_sw_c4", pwr_sw_en_o, 1'b1);
      step(1);
      check("dn_sw_c5", pwr_sw_en_o, 1'b0);
      step(2);
      check("dn_off_c7", domain_off_o, 1'b0);
      pwr_good_i = 1'b0;
      step(1);
      check("dn_off_c8", domain_off_o, 1'b1);
      check("dn_busy_c8", busy_o, 1'b0);

      // Brown-out: bring the domain up, then drop pwr_good while ON
      pwr_req_i = 1'b1;
      step(2);
      pwr_good_i = 1'b1;
      saw_on = 1'b0;
      for (int i = 0; i < 30 && !saw_on; i++) begin
         step(1);
         if (domain_on_o) saw_on = 1'b1;
      end
      check("bo_reach_on", saw_on, 1'b1);
      pwr_good_i = 1'b0;
      step(1);
      check("bo_clamp", clamp_o, 1'b1);
      check("bo_on", domain_on_o, 1'b0);
      pwr_req_i = 1'b0;
      step(3);
      check("bo_sw_3", pwr_sw_en_o, 1'b1);
      step(1);
      check("bo_sw_4", pwr_sw_en_o, 1'b0);
      step(1);
      check("bo_off", domain_off_o, 1'b1);

      // Short request pulse: full up then full down, invariant every cycle
      pwr_good_i = 1'b1;
      pwr_req_i  = 1'b1;
      step(2);
      pwr_req_i = 1'b0;
      saw_on  = 1'b0;
      saw_off = 1'b0;
      for (int i = 0; i < 60 && !saw_off; i++) begin
         step(1);
         check("pulse_inv", (clamp_o == 1'b0) ? pwr_sw_en_o : 1'b1, 1'b1);
         if (domain_on_o) saw_on = 1'b1;
         if (saw_on && !pwr_sw_en_o) pwr_good_i = 1'b0;
         if (saw_on && domain_off_o) saw_off = 1'b1;
      end
      check("pulse_saw_on", saw_on, 1'b1);
      check("pulse_saw_off", saw_off, 1'b1);

      // Reset while in SETTLE returns to OFF the next cycle
      pwr_good_i = 1'b1;
      pwr_req_i  = 1'b1;
      step(3);
      check("settle_busy", busy_o, 1'b1);
      check("settle_sw", pwr_sw_en_o, 1'b1);
      rst_i = 1'b1;
      step(1);
      check("mid_rst_off", domain_off_o, 1'b1);
      check("mid_rst_sw", pwr_sw_en_o, 1'b0);
      check("mid_rst_clamp", clamp_o, 1'b1);
      rst_i      = 1'b0;
      pwr_req_i  = 1'b0;
      pwr_good_i = 1'b0;
      step(2);

`ifdef PULP_ISO_CLAMP_CTRL_TIMEOUT_EN
      // Timeout: pwr_good never rises; 16 cycles in SW_ON then abort
      pwr_req_i = 1'b1;
      step(16);
      check("tmo_err_c16", err_o, 1'b0);
      check("tmo_sw_c16", pwr_sw_en_o, 1'b1);
      step(1);
      check("tmo_err_c17", err_o, 1'b1);
      check("tmo_clamp_c17", clamp_o, 1'b1);
      pwr_req_i = 1'b0;
      step(3);
      check("tmo_sw_c20", pwr_sw_en_o, 1'b1);
      step(1);
      check("tmo_sw_c21", pwr_sw_en_o, 1'b0);
      step(1);
      check("tmo_off_c22", domain_off_o, 1'b1);
      check("tmo_err_sticky", err_o, 1'b1);
`endif

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
